// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: round-robin arbiter for 4 requesters with optional hold limit and a one-cycle release gap
module rr_arbiter_4 #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_GRANT = 2'd1, S_REL = 2'd2} state_t;
    state_t           r_state;
    logic [3:0]       r_gnt;
    logic [1:0]       r_idx;
    logic [1:0]       r_ptr;
    logic [CNT_W-1:0] r_hold;
    logic             r_timeout;
    logic [7:0]       w_dbl;
    logic [3:0]       w_rot;
    logic [1:0]       w_off;
    logic [1:0]       w_sel;
    logic             w_start;
    logic             w_limit;

    // rotate requests so the pointer lands on bit 0, then take the first set bit
    always_comb begin
        w_dbl   = {req, req};
        w_rot   = w_dbl[r_ptr +: 4];
        w_off   = w_rot[0] ? 2'd0 : w_rot[1] ? 2'd1 : w_rot[2] ? 2'd2 : 2'd3;
        w_sel   = r_ptr + w_off;
        w_start = en && (|req);
        w_limit = (MAX_HOLD != 0) && (r_hold == CNT_W'(MAX_HOLD - 1));
    end

    // single-process FSM; grant, index and timeout are all registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_gnt     <= '0;
            r_idx     <= '0;
            r_ptr     <= '0;
            r_hold    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_GRANT;
                        r_gnt   <= 4'b0001 << w_sel;
                        r_idx   <= w_sel;
                        r_hold  <= '0;
                    end
                end
                S_GRANT: begin
                    r_hold <= r_hold + 1'b1;
                    if (!req[r_idx] || w_limit) begin
                        r_state   <= S_REL;
                        r_gnt     <= '0;
                        r_ptr     <= r_idx + 2'd1;
                        r_hold    <= '0;
                        // a drop coinciding with the limit counts as a normal release
                        r_timeout <= req[r_idx];
                    end
                end
                S_REL: begin
                    r_hold <= '0;
                    if (w_start) begin
                        r_state <= S_GRANT;
                        r_gnt   <= 4'b0001 << w_sel;
                        r_idx   <= w_sel;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= '0;
                    r_idx   <= '0;
                    r_hold  <= '0;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_idx;
    assign gnt_valid = |r_gnt;
    assign timeout   = r_timeout;
endmodule

// File: tb/tb_rr_arbiter_4.sv
// tb_rr_arbiter_4: scoreboard-driven checks of rotation, hold limit, enable gating and async reset
module tb_rr_arbiter_4;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;
    logic [7:0] exp_q [$];
    int         checks = 0;
    int         passed = 0;

    rr_arbiter_4 #(.MAX_HOLD(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic apply_reset;
        rst = 1'b1;
        req = 4'b0000;
        en  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        logic [7:0] e, got;
        #3;
        exp_q.push_back(8'h00);
        got = {gnt, gnt_idx, gnt_valid, timeout};
        e = exp_q.pop_front();
        checks++;
        if (got !== e) $display("FAIL reset_async got=%b exp=%b", got, e); else passed++;
        req = 4'b1111;
        en  = 1'b1;
        exp_q.push_back(8'h00);
        @(posedge clk);
        #1;
        got = {gnt, gnt_idx, gnt_valid, timeout};
        e = exp_q.pop_front();
        checks++;
        if (got !== e) $display("FAIL reset_held got=%b exp=%b", got, e); else passed++;
        rst = 1'b0;
        req = 4'b0000;
    endtask

    task automatic test_first_grant;
        logic [3:0] rq [3] = '{4'b0001, 4'b0000, 4'b0000};
        logic [7:0] ex [3] = '{8'b0001_00_1_0, 8'b0000_00_0_0, 8'b0000_00_0_0};
        logic [7:0] e, got;
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req = rq[i];
            exp_q.push_back(ex[i]);
            @(posedge clk);
            #1;
            got = {gnt, gnt_idx, gnt_valid, timeout};
            e = exp_q.pop_front();
            checks++;
            if (got !== e) $display("FAIL first_grant[%0d] got=%b exp=%b", i, got, e); else passed++;
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] e, got;
        int o;
        apply_reset();
        en = 1'b1;
        for (int r = 0; r < 5; r++) begin
            o = r % 4;
            for (int k = 0; k < 4; k++) begin
                req = (k < 3) ? 4'b1111 : (r == 4) ? 4'b0000 : ~4'(1 << o);
                exp_q.push_back((k < 3) ? {4'(1 << o), 2'(o), 2'b10} : {4'b0000, 2'(o), 2'b00});
                @(posedge clk);
                #1;
                got = {gnt, gnt_idx, gnt_valid, timeout};
                e = exp_q.pop_front();
                checks++;
                if (got !== e) $display("FAIL rotation r=%0d k=%0d got=%b exp=%b", r, k, got, e); else passed++;
            end
        end
    endtask

    task automatic test_hold_limit;
        logic [3:0] rq [11] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100,
                                4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
        logic [7:0] ex [11] = '{8'b0100_10_1_0, 8'b0100_10_1_0, 8'b0100_10_1_0, 8'b0100_10_1_0,
                                8'b0000_10_0_1, 8'b0100_10_1_0, 8'b0100_10_1_0, 8'b0100_10_1_0,
                                8'b0100_10_1_0, 8'b0000_10_0_0, 8'b0000_10_0_0};
        logic [7:0] e, got;
        apply_reset();
        en = 1'b1;
        for (int i = 0; i < 11; i++) begin
            req = rq[i];
            exp_q.push_back(ex[i]);
            @(posedge clk);
            #1;
            got = {gnt, gnt_idx, gnt_valid, timeout};
            e = exp_q.pop_front();
            checks++;
            if (got !== e) $display("FAIL hold_limit[%0d] got=%b exp=%b", i, got, e); else passed++;
        end
    endtask

    task automatic test_skip_empty;
        logic [3:0] rq [5] = '{4'b1010, 4'b1000, 4'b1000, 4'b0000, 4'b0000};
        logic [7:0] ex [5] = '{8'b0010_01_1_0, 8'b0000_01_0_0, 8'b1000_11_1_0,
                               8'b0000_11_0_0, 8'b0000_11_0_0};
        logic [7:0] e, got;
        apply_reset();
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req = rq[i];
            exp_q.push_back(ex[i]);
            @(posedge clk);
            #1;
            got = {gnt, gnt_idx, gnt_valid, timeout};
            e = exp_q.pop_front();
            checks++;
            if (got !== e) $display("FAIL skip_empty[%0d] got=%b exp=%b", i, got, e); else passed++;
        end
    endtask

    task automatic test_enable;
        logic [3:0] rq [8] = '{4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0010, 4'b0010, 4'b0010};
        logic       ee [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [7:0] ex [8] = '{8'b0000_00_0_0, 8'b0000_00_0_0, 8'b0001_00_1_0, 8'b0001_00_1_0,
                               8'b0001_00_1_0, 8'b0000_00_0_0, 8'b0000_00_0_0, 8'b0000_00_0_0};
        logic [7:0] e, got;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            req = rq[i];
            en  = ee[i];
            exp_q.push_back(ex[i]);
            @(posedge clk);
            #1;
            got = {gnt, gnt_idx, gnt_valid, timeout};
            e = exp_q.pop_front();
            checks++;
            if (got !== e) $display("FAIL enable[%0d] got=%b exp=%b", i, got, e); else passed++;
        end
    endtask

    task automatic test_async_reset;
        logic [3:0] rq [5] = '{4'b1000, 4'b1000, 4'b1001, 4'b0000, 4'b0000};
        logic [7:0] ex [5] = '{8'b1000_11_1_0, 8'b1000_11_1_0, 8'b0001_00_1_0,
                               8'b0000_00_0_0, 8'b0000_00_0_0};
        logic [7:0] e, got;
        apply_reset();
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                #2;
                rst = 1'b1;
                exp_q.push_back(8'h00);
                #1;
                got = {gnt, gnt_idx, gnt_valid, timeout};
                e = exp_q.pop_front();
                checks++;
                if (got !== e) $display("FAIL async_reset_mid got=%b exp=%b", got, e); else passed++;
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
            req = rq[i];
            exp_q.push_back(ex[i]);
            @(posedge clk);
            #1;
            got = {gnt, gnt_idx, gnt_valid, timeout};
            e = exp_q.pop_front();
            checks++;
            if (got !== e) $display("FAIL async_reset[%0d] got=%b exp=%b", i, got, e); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_first_grant();
        test_back_to_back();
        test_hold_limit();
        test_skip_empty();
        test_enable();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
